// File: rtl/show_char_render.sv
// show_char_render: fetches one glyph row by row from a font ROM and streams
// clipped foreground/background pixels over a valid/ready port.
module show_char_render #(
    parameter int          LCD_W       = 128,
    parameter int          LCD_H       = 160,
    parameter int          FONT12_BASE = 1520,
    parameter logic [15:0] FG_COLOR    = 16'hFFFF,
    parameter logic [15:0] BG_COLOR    = 16'h0000
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_i,
    input  logic        show_char_flag_i,
    input  logic [6:0]  ascii_num_i,
    input  logic [8:0]  start_x_i,
    input  logic [8:0]  start_y_i,
    input  logic        en_size_i,
    output logic [11:0] rom_addr_o,
    input  logic [7:0]  rom_data_i,
    output logic        pix_valid_o,
    input  logic        pix_ready_i,
    output logic [8:0]  pix_x_o,
    output logic [8:0]  pix_y_o,
    output logic [15:0] pix_color_o,
    output logic        busy_o,
    output logic        show_char_done_o
);
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, DRAW, DONE} state_t;

    state_t      state_q;
    logic [6:0]  ascii_q;
    logic [8:0]  x_q, y_q;
    logic        size_q;
    logic [3:0]  row_q;
    logic [2:0]  col_q;
    logic [7:0]  sh_q;
    logic [11:0] rom_addr_q;
    logic        pix_valid_q, busy_q, done_q;
    logic [8:0]  pix_x_q, pix_y_q;
    logic [15:0] pix_color_q;

    logic [2:0]  col_d;
    logic [3:0]  row_d;
    logic [9:0]  x_sum, y_sum;
    logic [7:0]  glyph_d, bits_d;
    logic        in_panel, advance, last_col, last_row;

    function automatic logic [11:0] addr_f(input logic [6:0] a, input logic s, input logic [3:0] r);
        return s ? {1'b0, a, 4'b0000} + {8'd0, r}
                 : 12'(FONT12_BASE) + {5'd0, a} * 12'd12 + {8'd0, r};
    endfunction

    // WAIT loads column 0 straight from the ROM byte; DRAW loads the next column from the shifter.
    always_comb begin
        col_d    = (state_q == WAIT) ? 3'd0 : col_q + 3'd1;
        row_d    = row_q + 4'd1;
        x_sum    = {1'b0, x_q} + {7'd0, col_d};
        y_sum    = {1'b0, y_q} + {6'd0, row_q};
        in_panel = (x_sum < 10'(LCD_W)) && (y_sum < 10'(LCD_H));
        glyph_d  = (ascii_q > 7'd94) ? 8'd0 : rom_data_i;
        bits_d   = (state_q == WAIT) ? glyph_d : sh_q;
        advance  = !pix_valid_q || pix_ready_i;
        last_col = col_q == (size_q ? 3'd7 : 3'd5);
        last_row = row_q == (size_q ? 4'd15 : 4'd11);
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state_q     <= IDLE;
            ascii_q     <= '0;
            x_q         <= '0;
            y_q         <= '0;
            size_q      <= 1'b0;
            row_q       <= '0;
            col_q       <= '0;
            sh_q        <= '0;
            rom_addr_q  <= '0;
            pix_valid_q <= 1'b0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            pix_color_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (show_char_flag_i) begin
                    ascii_q    <= ascii_num_i;
                    x_q        <= start_x_i;
                    y_q        <= start_y_i;
                    size_q     <= en_size_i;
                    row_q      <= '0;
                    rom_addr_q <= addr_f(ascii_num_i, en_size_i, 4'd0);
                    busy_q     <= 1'b1;
                    state_q    <= FETCH;
                end
                FETCH: state_q <= WAIT;
                WAIT, DRAW: begin
                    if (state_q == WAIT || (advance && !last_col)) begin
                        sh_q        <= bits_d << 1;
                        pix_color_q <= bits_d[7] ? FG_COLOR : BG_COLOR;
                        pix_x_q     <= x_sum[8:0];
                        pix_y_q     <= y_sum[8:0];
                        pix_valid_q <= in_panel;
                        col_q       <= col_d;
                        state_q     <= DRAW;
                    end else if (advance) begin
                        pix_valid_q <= 1'b0;
                        if (last_row) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            row_q      <= row_d;
                            rom_addr_q <= addr_f(ascii_q, size_q, row_d);
                            state_q    <= FETCH;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rom_addr_o       = rom_addr_q;
    assign pix_valid_o      = pix_valid_q;
    assign pix_x_o          = pix_x_q;
    assign pix_y_o          = pix_y_q;
    assign pix_color_o      = pix_color_q;
    assign busy_o           = busy_q;
    assign show_char_done_o = done_q;
endmodule

// File: tb/tb_show_char_render.sv
// tb_show_char_render: directed glyph renders against a synthetic font ROM,
// checking beats, ROM addresses, timing, clipping, backpressure and reset.
module tb_show_char_render;
    logic        clk = 1'b0, rst = 1'b1, flag = 1'b0, size = 1'b0, pix_ready = 1'b1;
    logic [6:0]  ascii = '0;
    logic [8:0]  sx = '0, sy = '0;
    logic [11:0] rom_addr;
    logic [7:0]  rom_data = '0;
    logic        pix_valid, busy, done;
    logic [8:0]  pix_x, pix_y;
    logic [15:0] pix_color;
    int          checks = 0, errors = 0, cyc = 0;
    bit          rnd_ready = 1'b0;

    typedef struct {logic [8:0] x; logic [8:0] y; logic [15:0] c; int t;} beat_t;
    beat_t       beats[$];
    logic [11:0] addrs[$];
    logic [11:0] last_addr = '0;
    int          done_cnt = 0, done_cyc = 0, stalls = 0, viol = 0;
    logic        pv_stall = 1'b0;
    logic [8:0]  px, py;
    logic [15:0] pc;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] rom_fn(input logic [11:0] a);
        logic [11:0] m;
        m = a * 12'd29 + 12'd7;
        return m[9:2] ^ {a[3:0], a[11:8]};
    endfunction

    always @(posedge clk) rom_data <= rom_fn(rom_addr);

    show_char_render dut (
        .sys_clk_i(clk), .sys_rst_i(rst), .show_char_flag_i(flag),
        .ascii_num_i(ascii), .start_x_i(sx), .start_y_i(sy), .en_size_i(size),
        .rom_addr_o(rom_addr), .rom_data_i(rom_data),
        .pix_valid_o(pix_valid), .pix_ready_i(pix_ready),
        .pix_x_o(pix_x), .pix_y_o(pix_y), .pix_color_o(pix_color),
        .busy_o(busy), .show_char_done_o(done)
    );

    initial forever begin
        @(posedge clk);
        #1 pix_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (pv_stall && (!pix_valid || pix_x !== px || pix_y !== py || pix_color !== pc)) viol++;
        pv_stall = pix_valid && !pix_ready;
        if (pv_stall) stalls++;
        px = pix_x;
        py = pix_y;
        pc = pix_color;
        if (pix_valid && pix_ready) beats.push_back('{pix_x, pix_y, pix_color, cyc});
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (rom_addr !== last_addr) addrs.push_back(rom_addr);
        last_addr = rom_addr;
    end

    task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run(input string tag, input logic [6:0] a, input logic [8:0] x0, input logic [8:0] y0,
                       input logic s, input bit rnd, input int lat, input bit midflag, input bit dflag);
        int t0, idx, h, w;
        logic [7:0] g;
        logic [9:0] ex, ey;
        logic [11:0] ea;
        beats.delete();
        addrs.delete();
        done_cnt = 0;
        stalls = 0;
        viol = 0;
        rnd_ready = rnd;
        h = s ? 16 : 12;
        w = s ? 8 : 6;
        @(posedge clk);
        #1 ascii = a; sx = x0; sy = y0; size = s; flag = 1'b1; t0 = cyc;
        @(posedge clk);
        #1 flag = 1'b0; ascii = ~a; sx = ~x0; sy = ~y0; size = ~s;
        @(negedge clk) chk({tag, ".busy_t1"}, 48'(busy), 48'd1);
        if (midflag) begin
            repeat (40) @(posedge clk);
            #1 flag = 1'b1; ascii = 7'd5; sx = 9'd0; sy = 9'd0;
            @(posedge clk);
            #1 flag = 1'b0;
        end
        if (dflag) begin
            while (cyc < t0 + lat) begin
                @(posedge clk);
                #1;
            end
            flag = 1'b1; ascii = 7'd1;
            @(posedge clk);
            #1 flag = 1'b0;
        end
        for (int i = 0; i < 4000 && done_cnt == 0; i++) begin
            @(posedge clk);
            #1;
        end
        if (lat > 0) chk({tag, ".done_cyc"}, 48'(done_cyc), 48'(t0 + lat));
        @(negedge clk) chk({tag, ".busy_after"}, 48'(busy), 48'd0);
        repeat (200) @(posedge clk);
        #1;
        chk({tag, ".done_cnt"}, 48'(done_cnt), 48'd1);
        chk({tag, ".idle_busy"}, 48'(busy), 48'd0);
        chk({tag, ".addr_cnt"}, 48'(addrs.size()), 48'(h));
        for (int r = 0; r < h && r < addrs.size(); r++) begin
            ea = s ? 12'(a) * 12'd16 + 12'(r) : 12'd1520 + 12'(a) * 12'd12 + 12'(r);
            chk($sformatf("%s.addr%0d", tag, r), 48'(addrs[r]), 48'(ea));
        end
        idx = 0;
        for (int r = 0; r < h; r++) begin
            ea = s ? 12'(a) * 12'd16 + 12'(r) : 12'd1520 + 12'(a) * 12'd12 + 12'(r);
            g = (a > 7'd94) ? 8'd0 : rom_fn(ea);
            for (int c = 0; c < w; c++) begin
                ex = {1'b0, x0} + 10'(c);
                ey = {1'b0, y0} + 10'(r);
                if (ex < 10'd128 && ey < 10'd160) begin
                    if (idx < beats.size())
                        chk($sformatf("%s.beat%0d", tag, idx), {beats[idx].x, beats[idx].y, beats[idx].c},
                            {ex[8:0], ey[8:0], g[7 - c] ? 16'hFFFF : 16'h0000});
                    idx++;
                end
            end
        end
        chk({tag, ".beats"}, 48'(beats.size()), 48'(idx));
        if (lat > 0 && beats.size() > 0) chk({tag, ".first_t"}, 48'(beats[0].t), 48'(t0 + 3));
        if (rnd) begin
            chk({tag, ".stalled"}, 48'(stalls > 0), 48'd1);
            chk({tag, ".stable"}, 48'(viol), 48'd0);
        end
        rnd_ready = 1'b0;
    endtask

    initial begin
        int t0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset", {rom_addr, pix_valid, pix_x, pix_y, pix_color, busy, done}, 48'd0);
        run("c1", 7'd33, 9'd56, 9'd0, 1'b1, 1'b0, 161, 1'b0, 1'b1);
        run("c2", 7'd16, 9'd0, 9'd16, 1'b0, 1'b0, 97, 1'b0, 1'b0);
        run("c3", 7'd33, 9'd56, 9'd0, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        run("c4x", 7'd33, 9'd124, 9'd0, 1'b1, 1'b0, 161, 1'b0, 1'b0);
        run("c4y", 7'd33, 9'd0, 9'd152, 1'b1, 1'b0, 161, 1'b0, 1'b0);
        run("wrap", 7'd1, 9'd510, 9'd0, 1'b0, 1'b0, 97, 1'b0, 1'b0);
        run("c5", 7'd100, 9'd10, 9'd20, 1'b1, 1'b0, 161, 1'b1, 1'b0);
        done_cnt = 0;
        @(posedge clk);
        #1 ascii = 7'd33; sx = 9'd56; sy = 9'd0; size = 1'b1; flag = 1'b1; t0 = cyc;
        @(posedge clk);
        #1 flag = 1'b0;
        while (cyc < t0 + 55) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("c6.rst_out", {rom_addr, pix_valid, pix_x, pix_y, pix_color, busy, done}, 48'd0);
        repeat (200) @(posedge clk);
        #1;
        chk("c6.no_done", 48'(done_cnt), 48'd0);
        chk("c6.idle", 48'(busy), 48'd0);
        run("c6", 7'd33, 9'd56, 9'd0, 1'b1, 1'b0, 161, 1'b0, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
